// File: rtl/arm_multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// arm_multicycle_ctrl_if
//   Bundle between the multicycle ARM controller and its datapath.
//   master : the controller. It reads the instruction fields, ALU flags and the
//            memory-ready handshake, and drives the enables, mux selects and
//            the State observation port.
//   slave  : the datapath / memory side, or a testbench standing in for it.
//   Signals:
//     Instr[19:0]   Instr[31:12] from the IR: Cond, Op, Funct, Rn, Rd
//     ALUFlags[3:0] NZCV from the ALU in the cycle it computes
//     MemReady      memory completes the access presented this cycle
//     PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, RegSrc, ImmSrc,
//     ALUSrcA, ALUSrcB, ALUControl, ResultSrc, carry, Shift, State
// ---------------------------------------------------------------------------
interface arm_multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [19:0]        Instr;
    logic [3:0]         ALUFlags;
    logic               MemReady;
    logic               PCWrite;
    logic               IRWrite;
    logic               AdrSrc;
    logic               MemWrite;
    logic               RegWrite;
    logic [1:0]         RegSrc;
    logic [1:0]         ImmSrc;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [2:0]         ALUControl;
    logic [1:0]         ResultSrc;
    logic               carry;
    logic               Shift;
    logic [STATE_W-1:0] State;

    modport master (
        input  Instr, ALUFlags, MemReady,
        output PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ALUControl, ResultSrc, carry, Shift, State
    );

    modport slave (
        output Instr, ALUFlags, MemReady,
        input  PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ALUControl, ResultSrc, carry, Shift, State
    );
endinterface

// File: rtl/arm_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// arm_multicycle_ctrl
//   Moore sequencer for the multicycle ARM datapath. A single memory port is
//   shared by fetch and load/store, and a single ALU by PC+4 and execute. The
//   block also holds the NZCV register and evaluates the condition field.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low; forces FETCH, NZCV=FLAG_RST and
//            suppresses every write enable while low
//     bus    arm_multicycle_ctrl_if.master (instruction fields, flags,
//            MemReady in; enables, mux selects and State out)
//   State encoding: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5
//                   EXECR=6 EXECI=7 ALUWB=8 BRANCH=9
// ---------------------------------------------------------------------------
module arm_multicycle_ctrl #(
    parameter int         STATE_W  = 4,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic                  clk,
    input  logic                  reset,
    arm_multicycle_ctrl_if.master bus
);
    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECR  = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXECI  = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(9);

    logic [STATE_W-1:0] state_q, state_d;
    logic [3:0]         flags_q, flags_d;

    // Instruction field split (Instr holds bits 31:12 of the instruction).
    logic [3:0] cond, cmd, rd, unused_rn;
    logic [1:0] op;
    logic [5:0] funct;
    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign funct     = bus.Instr[13:8];
    assign unused_rn = bus.Instr[7:4];
    assign rd        = bus.Instr[3:0];
    assign cmd       = funct[4:1];

    // ARM condition table against the stored NZCV; 1111 never executes.
    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: cond_check = z;
            4'b0001: cond_check = ~z;
            4'b0010: cond_check = cf;
            4'b0011: cond_check = ~cf;
            4'b0100: cond_check = n;
            4'b0101: cond_check = ~n;
            4'b0110: cond_check = v;
            4'b0111: cond_check = ~v;
            4'b1000: cond_check = cf & ~z;
            4'b1001: cond_check = ~cf | z;
            4'b1010: cond_check = (n == v);
            4'b1011: cond_check = (n != v);
            4'b1100: cond_check = ~z & (n == v);
            4'b1101: cond_check = z | (n != v);
            4'b1110: cond_check = 1'b1;
            default: cond_check = 1'b0;
        endcase
    endfunction

    // Data-processing command decode. cmd_ok=0 turns the instruction into a
    // NOP: no flag update and no writeback.
    logic [2:0] alu_ctl;
    logic       cmd_ok, is_cmp, is_adc, is_mov, nz_only;
    always_comb begin
        alu_ctl = 3'b000;
        cmd_ok  = 1'b1;
        is_cmp  = 1'b0;
        is_adc  = 1'b0;
        is_mov  = 1'b0;
        nz_only = 1'b0;
        case (cmd)
            4'b0100: alu_ctl = 3'b000;
            4'b0010: alu_ctl = 3'b001;
            4'b1010: begin alu_ctl = 3'b001; is_cmp = 1'b1; end
            4'b0000: begin alu_ctl = 3'b010; nz_only = 1'b1; end
            4'b1100: begin alu_ctl = 3'b011; nz_only = 1'b1; end
            4'b0001: begin alu_ctl = 3'b100; nz_only = 1'b1; end
            4'b0101: begin alu_ctl = 3'b000; is_adc = 1'b1; end
            4'b1101: begin alu_ctl = 3'b000; is_mov = 1'b1; nz_only = 1'b1; end
            default: cmd_ok = 1'b0;
        endcase
    end

    // State and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            flags_q <= FLAG_RST;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Next state and next flags.
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        case (state_q)
            S_FETCH:  if (bus.MemReady) state_d = S_DECODE;
            S_DECODE: begin
                if (!cond_check(cond, flags_q)) state_d = S_FETCH;
                else begin
                    case (op)
                        2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                        2'b01:   state_d = S_MEMADR;
                        2'b10:   state_d = S_BRANCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_EXECR, S_EXECI: begin
                state_d = S_ALUWB;
                // Logical ops and MOV leave C and V untouched.
                if (cmd_ok && (funct[0] || is_cmp))
                    flags_d = nz_only ? {bus.ALUFlags[3:2], flags_q[1:0]} : bus.ALUFlags;
            end
            S_ALUWB:  state_d = S_FETCH;
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.MemReady) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (bus.MemReady) state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs.
    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.RegSrc     = 2'b00;
        bus.ImmSrc     = op;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = 3'b000;
        bus.ResultSrc  = 2'b00;
        bus.carry      = 1'b0;
        bus.Shift      = 1'b0;
        bus.State      = state_q;
        case (state_q)
            S_FETCH: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.MemReady;
                bus.PCWrite   = bus.MemReady;
            end
            S_DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            S_EXECR, S_EXECI: begin
                bus.ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                bus.ALUControl = alu_ctl;
                bus.carry      = is_adc & flags_q[1];
                bus.Shift      = is_mov;
            end
            S_ALUWB: begin
                bus.RegWrite = cmd_ok & ~is_cmp;
                bus.PCWrite  = cmd_ok & ~is_cmp & (rd == 4'hF);
            end
            S_MEMADR: bus.ALUSrcB = 2'b01;
            S_MEMRD:  bus.AdrSrc  = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
                bus.PCWrite   = (rd == 4'hF);
            end
            S_MEMWR: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                bus.RegSrc   = 2'b10;
            end
            S_BRANCH: begin
                bus.RegSrc    = 2'b01;
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.PCWrite   = 1'b1;
            end
            default: ;
        endcase
        // Reset is asynchronous, so the enables must drop with it rather than
        // waiting for the state register to settle.
        if (!reset) begin
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.MemWrite = 1'b0;
            bus.RegWrite = 1'b0;
        end
    end
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arm_multicycle_ctrl
//   Self-checking bench for arm_multicycle_ctrl: a table of instructions with
//   hand-derived per-instruction totals, directed cycle-by-cycle sequences for
//   the multi-cycle corners, and random instructions checked against an
//   instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_arm_multicycle_ctrl;
    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXECR  = 4'd6;
    localparam logic [3:0] ST_EXECI  = 4'd7;
    localparam logic [3:0] ST_ALUWB  = 4'd8;
    localparam logic [3:0] ST_BRANCH = 4'd9;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arm_multicycle_ctrl_if #(.STATE_W(4)) bus ();

    arm_multicycle_ctrl #(.STATE_W(4), .FLAG_RST(4'b0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [3:0] m_flags;

    // Per-instruction record: stimulus and expected totals over the instruction.
    typedef struct {
        logic [19:0] ins;
        logic [3:0]  af;
        int          wf;     // MemReady=0 cycles during fetch
        int          wd;     // MemReady=0 cycles during the data access
        int          cyc;
        int          pcw;
        int          regw;
        int          memw;
        int          carry;
        int          shift;
        logic [3:0]  nzcv;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive inputs after the falling edge and sample outputs 1 time unit later.
    task automatic step(input logic [19:0] ins, input logic mr, input logic [3:0] af);
        @(negedge clk);
        bus.Instr    = ins;
        bus.MemReady = mr;
        bus.ALUFlags = af;
        #1;
    endtask

    // ARM condition rule: even codes test a predicate, the next odd code negates it.
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        base = 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: return (c == 4'hE);
        endcase
        return base ^ c[0];
    endfunction

    function automatic vec_t model_expect(input logic [19:0] ins, input logic [3:0] af,
                                          input int wf, input int wd, input logic [3:0] fl);
        vec_t e;
        logic [1:0] op;
        logic [3:0] cmd, rd;
        logic sb;
        bit known, logical;
        op  = ins[15:14];
        cmd = ins[12:9];
        sb  = ins[8];
        rd  = ins[3:0];
        known   = (cmd inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'hA, 4'hC, 4'hD});
        logical = (cmd inside {4'h0, 4'h1, 4'hC, 4'hD});
        e = '{ins:ins, af:af, wf:wf, wd:wd, cyc:2, pcw:1, regw:0, memw:0,
              carry:0, shift:0, nzcv:fl};
        if (cond_model(ins[19:16], fl)) begin
            case (op)
                2'b00: begin
                    e.cyc = 4;
                    if (known && cmd != 4'hA) begin
                        e.regw = 1;
                        if (rd == 4'hF) e.pcw = 2;
                    end
                    if (cmd == 4'h5) e.carry = int'(fl[1]);
                    if (cmd == 4'hD) e.shift = 1;
                    if (known && (sb || cmd == 4'hA))
                        e.nzcv = logical ? {af[3:2], fl[1:0]} : af;
                end
                2'b01: begin
                    if (sb) begin
                        e.cyc  = 5 + wd;
                        e.regw = 1;
                        if (rd == 4'hF) e.pcw = 2;
                    end else begin
                        e.cyc  = 4 + wd;
                        e.memw = wd + 1;
                    end
                end
                2'b10: begin e.cyc = 3; e.pcw = 2; end
                default: ;
            endcase
        end
        e.cyc += wf;
        return e;
    endfunction

    // Run one instruction for its expected length with a memory that stalls
    // wf cycles on fetch and wd cycles on the data access, then compare totals.
    task automatic apply(input string tag, input vec_t v);
        int n_pcw, n_irw, n_regw, n_memw, n_carry, n_shift;
        bit mem_op;
        logic mr;
        n_pcw = 0; n_irw = 0; n_regw = 0; n_memw = 0; n_carry = 0; n_shift = 0;
        mem_op = (v.ins[15:14] == 2'b01);
        for (int k = 0; k < v.cyc; k++) begin
            mr = !((k < v.wf) || (mem_op && k >= v.wf + 3 && k < v.wf + 3 + v.wd));
            step(v.ins, mr, v.af);
            if (k == 0) chk({tag, "_start_state"}, 32'(bus.State), 32'(ST_FETCH));
            n_pcw   += int'(bus.PCWrite);
            n_irw   += int'(bus.IRWrite);
            n_regw  += int'(bus.RegWrite);
            n_memw  += int'(bus.MemWrite);
            n_carry += int'(bus.carry);
            n_shift += int'(bus.Shift);
        end
        chk({tag, "_irwrite"},  n_irw,   1);
        chk({tag, "_pcwrite"},  n_pcw,   v.pcw);
        chk({tag, "_regwrite"}, n_regw,  v.regw);
        chk({tag, "_memwrite"}, n_memw,  v.memw);
        chk({tag, "_carry"},    n_carry, v.carry);
        chk({tag, "_shift"},    n_shift, v.shift);
        chk({tag, "_nzcv"},     32'(dut.flags_q), 32'(v.nzcv));
    endtask

    initial begin
        //            ins       af      wf wd cyc pcw rw mw ca sh nzcv
        tbl[0]  = '{20'hE2921, 4'b0100, 0, 0, 4, 1, 1, 0, 0, 0, 4'b0100};
        tbl[1]  = '{20'h0A000, 4'b0000, 0, 0, 3, 2, 0, 0, 0, 0, 4'b0100};
        tbl[2]  = '{20'hE3510, 4'b1000, 0, 0, 4, 1, 0, 0, 0, 0, 4'b1000};
        tbl[3]  = '{20'h0A000, 4'b0000, 0, 0, 2, 1, 0, 0, 0, 0, 4'b1000};
        tbl[4]  = '{20'h4A000, 4'b0000, 0, 0, 3, 2, 0, 0, 0, 0, 4'b1000};
        tbl[5]  = '{20'hE1A0F, 4'b1111, 0, 0, 4, 2, 1, 0, 0, 1, 4'b1000};
        tbl[6]  = '{20'hE5921, 4'b0000, 1, 2, 8, 1, 1, 0, 0, 0, 4'b1000};
        tbl[7]  = '{20'hE5821, 4'b0000, 0, 1, 5, 1, 0, 2, 0, 0, 4'b1000};
        tbl[8]  = '{20'hE0113, 4'b0110, 0, 0, 4, 1, 1, 0, 0, 0, 4'b0100};
        tbl[9]  = '{20'hE2B45, 4'b0011, 0, 0, 4, 1, 1, 0, 0, 0, 4'b0011};
        tbl[10] = '{20'hE0312, 4'b1100, 0, 0, 4, 1, 1, 0, 0, 0, 4'b1111};
        tbl[11] = '{20'hE0F12, 4'b0000, 0, 0, 4, 1, 0, 0, 0, 0, 4'b1111};
        tbl[12] = '{20'hF2921, 4'b0000, 0, 0, 2, 1, 0, 0, 0, 0, 4'b1111};
        tbl[13] = '{20'hEC000, 4'b0000, 0, 0, 2, 1, 0, 0, 0, 0, 4'b1111};
        tbl[14] = '{20'hE2B45, 4'b0000, 0, 0, 4, 1, 1, 0, 1, 0, 4'b0000};
        tbl[15] = '{20'hC2921, 4'b1001, 0, 0, 4, 1, 1, 0, 0, 0, 4'b1001};
        tbl[16] = '{20'hBA000, 4'b0000, 0, 0, 2, 1, 0, 0, 0, 0, 4'b1001};
        tbl[17] = '{20'hE591F, 4'b0000, 0, 0, 5, 2, 1, 0, 0, 0, 4'b1001};

        // Reset state, with MemReady high to show the enables are suppressed.
        reset        = 1'b0;
        bus.Instr    = 20'h0;
        bus.MemReady = 1'b1;
        bus.ALUFlags = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state",    32'(bus.State),    32'(ST_FETCH));
        chk("rst_irwrite",  32'(bus.IRWrite),  0);
        chk("rst_pcwrite",  32'(bus.PCWrite),  0);
        chk("rst_memwrite", 32'(bus.MemWrite), 0);
        chk("rst_regwrite", 32'(bus.RegWrite), 0);
        chk("rst_nzcv",     32'(dut.flags_q),  0);
        @(negedge clk);
        bus.MemReady = 1'b0;
        reset        = 1'b1;

        for (int i = 0; i < 18; i++) apply($sformatf("tbl%0d", i), tbl[i]);

        // Random instructions against the reference model.
        m_flags = 4'b1001;
        for (int n = 0; n < 120; n++) begin
            logic [3:0] c, cmdr, rdr, af;
            logic [1:0] opr;
            logic [19:0] ins;
            vec_t v;
            logic [3:0] known_cmds [8];
            known_cmds = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'hA, 4'hC, 4'hD};
            c    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
            opr  = 2'($urandom_range(0, 3));
            cmdr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                : known_cmds[$urandom_range(0, 7)];
            rdr  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            af   = 4'($urandom_range(0, 15));
            ins  = {c, opr, 1'($urandom_range(0, 1)), cmdr, 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), rdr};
            v = model_expect(ins, af, $urandom_range(0, 2), $urandom_range(0, 3), m_flags);
            apply($sformatf("rnd%0d", n), v);
            m_flags = v.nzcv;
        end

        // ADDS R1,R2,#0 with Z from the ALU: four-cycle trace.
        step(20'hE2921, 1'b1, 4'b0100);
        chk("adds_fetch", 32'(bus.State), 32'(ST_FETCH));
        chk("adds_fetch_irw", 32'(bus.IRWrite), 1);
        step(20'hE2921, 1'b1, 4'b0100);
        chk("adds_decode", 32'(bus.State), 32'(ST_DECODE));
        step(20'hE2921, 1'b1, 4'b0100);
        chk("adds_execi", 32'(bus.State), 32'(ST_EXECI));
        chk("adds_execi_srcb", 32'(bus.ALUSrcB), 1);
        chk("adds_execi_regw", 32'(bus.RegWrite), 0);
        step(20'hE2921, 1'b1, 4'b0100);
        chk("adds_aluwb", 32'(bus.State), 32'(ST_ALUWB));
        chk("adds_aluwb_regw", 32'(bus.RegWrite), 1);
        chk("adds_nzcv", 32'(dut.flags_q), 32'(4'b0100));

        // BEQ taken with Z=1.
        step(20'h0A000, 1'b1, 4'b0000);
        step(20'h0A000, 1'b1, 4'b0000);
        step(20'h0A000, 1'b1, 4'b0000);
        chk("beq_t_branch", 32'(bus.State), 32'(ST_BRANCH));
        chk("beq_t_pcw", 32'(bus.PCWrite), 1);
        chk("beq_t_regsrc", 32'(bus.RegSrc), 1);

        // CMP R1,#5 clears Z, no writeback.
        for (int k = 0; k < 4; k++) step(20'hE3510, 1'b1, 4'b0000);
        chk("cmp_aluwb", 32'(bus.State), 32'(ST_ALUWB));
        chk("cmp_regw", 32'(bus.RegWrite), 0);
        chk("cmp_pcw", 32'(bus.PCWrite), 0);
        chk("cmp_nzcv", 32'(dut.flags_q), 0);

        // BEQ not taken: DECODE returns to FETCH without PCWrite.
        step(20'h0A000, 1'b1, 4'b0000);
        step(20'h0A000, 1'b1, 4'b0000);
        chk("beq_nt_decode", 32'(bus.State), 32'(ST_DECODE));
        chk("beq_nt_pcw", 32'(bus.PCWrite), 0);

        // LDR with MemReady low for 3 cycles in MEMRD.
        step(20'hE5921, 1'b1, 4'b0000);
        chk("beq_nt_back", 32'(bus.State), 32'(ST_FETCH));
        step(20'hE5921, 1'b1, 4'b0000);
        step(20'hE5921, 1'b1, 4'b0000);
        chk("ldr_memadr", 32'(bus.State), 32'(ST_MEMADR));
        chk("ldr_immsrc", 32'(bus.ImmSrc), 1);
        for (int k = 0; k < 4; k++) begin
            step(20'hE5921, (k == 3), 4'b0000);
            chk($sformatf("ldr_memrd%0d", k), 32'(bus.State), 32'(ST_MEMRD));
            chk($sformatf("ldr_memrd%0d_adr", k), 32'(bus.AdrSrc), 1);
            chk($sformatf("ldr_memrd%0d_regw", k), 32'(bus.RegWrite), 0);
        end
        step(20'hE5921, 1'b1, 4'b0000);
        chk("ldr_memwb", 32'(bus.State), 32'(ST_MEMWB));
        chk("ldr_memwb_regw", 32'(bus.RegWrite), 1);
        chk("ldr_memwb_res", 32'(bus.ResultSrc), 1);

        // MOV R15,R2: Shift in EXECR, RegWrite and PCWrite in ALUWB.
        step(20'hE1A0F, 1'b1, 4'b1111);
        step(20'hE1A0F, 1'b1, 4'b1111);
        step(20'hE1A0F, 1'b1, 4'b1111);
        chk("mov_execr", 32'(bus.State), 32'(ST_EXECR));
        chk("mov_shift", 32'(bus.Shift), 1);
        step(20'hE1A0F, 1'b1, 4'b1111);
        chk("mov_regw", 32'(bus.RegWrite), 1);
        chk("mov_pcw", 32'(bus.PCWrite), 1);
        chk("mov_nzcv", 32'(dut.flags_q), 0);

        // Reset in the middle of a stalled store.
        for (int k = 0; k < 4; k++) step(20'hE2921, 1'b1, 4'b1111);
        chk("pre_rst_nzcv", 32'(dut.flags_q), 32'(4'b1111));
        step(20'hE5821, 1'b1, 4'b0000);
        step(20'hE5821, 1'b1, 4'b0000);
        step(20'hE5821, 1'b1, 4'b0000);
        step(20'hE5821, 1'b0, 4'b0000);
        chk("str_memwr", 32'(bus.State), 32'(ST_MEMWR));
        chk("str_memw", 32'(bus.MemWrite), 1);
        chk("str_regsrc", 32'(bus.RegSrc), 2);
        bus.MemReady = 1'b1;
        reset        = 1'b0;
        #1;
        chk("arst_state", 32'(bus.State), 32'(ST_FETCH));
        chk("arst_memw", 32'(bus.MemWrite), 0);
        chk("arst_irw", 32'(bus.IRWrite), 0);
        chk("arst_nzcv", 32'(dut.flags_q), 0);
        @(posedge clk);
        #1;
        chk("arst_hold_state", 32'(bus.State), 32'(ST_FETCH));
        chk("arst_hold_pcw", 32'(bus.PCWrite), 0);
        @(negedge clk);
        bus.MemReady = 1'b0;
        reset        = 1'b1;
        step(20'hE2921, 1'b1, 4'b0000);
        chk("post_rst_irw", 32'(bus.IRWrite), 1);
        step(20'hE2921, 1'b1, 4'b0000);
        chk("post_rst_decode", 32'(bus.State), 32'(ST_DECODE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
